// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus a fixed-latency
// iterative shift-add multiplier, with valid/ready on both sides.
module seq_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             busy_o
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_ADDI = 3'b110;
  localparam logic [2:0] OP_SRAI = 3'b111;

  localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_OUT
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;

  logic               accept;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   acc_sum;

  assign in_ready_o  = (state_q == S_IDLE) && !rst_i;
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = (state_q == S_OUT);
  assign busy_o      = (state_q != S_IDLE);
  assign data_o      = data_q;
  assign zero_o      = zero_q;
  assign shamt       = data2_i[SHAMT_W-1:0];
  assign acc_sum     = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    alu_res = '0;
    case (ALUCtrl_i)
      OP_AND:           alu_res = data1_i & data2_i;
      OP_XOR:           alu_res = data1_i ^ data2_i;
      OP_SLL:           alu_res = data1_i << shamt;
      OP_ADD, OP_ADDI:  alu_res = data1_i + data2_i;
      OP_SUB:           alu_res = data1_i - data2_i;
      OP_SRAI:          alu_res = WIDTH'($signed(data1_i) >>> shamt);
      default:          alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    zero_d   = zero_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (ALUCtrl_i == OP_MUL) begin
            mcand_d  = data1_i;
            mplier_d = data2_i;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            data_d  = alu_res;
            zero_d  = (alu_res == '0);
            state_d = S_OUT;
          end
        end
      end
      S_MUL: begin
        // Always runs all WIDTH iterations so the latency is data-independent.
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          data_d  = acc_sum;
          zero_d  = (acc_sum == '0);
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      zero_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      zero_q   <= zero_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Execution unit that consumes the 3-bit ALU control code from the ALU control decoder, together with two operands.
- Single-cycle ops (and, xor, sll, add, sub, addi, srai) return one cycle after accept.
- mul runs as an iterative shift-add multiplier over WIDTH cycles.
- Valid/ready handshake on both input and output sides, so the EX stage can stall on multiply and on downstream backpressure.

Parameters:
- WIDTH, 32, operand/result width.
- SHAMT_W, 5, shift-amount bits taken from data2_i; equals log2(WIDTH).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- in_valid_i  in  1  request carries a valid op.
- in_ready_o  out  1  unit can accept an op.
- ALUCtrl_i  in  3  op code: 000 and, 001 xor, 010 sll, 011 add, 100 sub, 101 mul, 110 addi, 111 srai.
- data1_i  in  WIDTH  operand 1.
- data2_i  in  WIDTH  operand 2 (immediate for addi/srai, already extended).
- out_valid_o  out  1  data_o/zero_o valid.
- out_ready_i  in  1  consumer takes result.
- data_o  out  WIDTH  registered result.
- zero_o  out  1  registered (result == 0).
- busy_o  out  1  state != IDLE.

Behaviour:
- Clocking and reset: one clock (clk_i); reset is synchronous and active-high (rst_i).
- States: IDLE, MUL, OUT.
- Reset:
  - state=IDLE, data_o=0, zero_o=0, out_valid_o=0, multiplier regs and counter=0.
  - in_ready_o=0 while rst_i=1, and 1 in the first cycle after release.
  - Reset mid-MUL or in OUT aborts the operation; no result is ever presented.
- in_ready_o = (state==IDLE) && !rst_i. Accept = in_valid_i && in_ready_o.
- Operands and ALUCtrl_i are sampled only at the accept edge. Later input changes are ignored.
- Non-mul op accepted at edge E0:
  - result and zero registered at E0; state -> OUT.
  - out_valid_o high in the cycle after accept (latency 1).
- mul accepted at E0:
  - latch mcand=data1_i, mplier=data2_i, acc=0, cnt=0; state -> MUL.
  - Each MUL edge: if mplier[0], acc += mcand (mod 2^WIDTH); mcand <<= 1; mplier >>= 1; cnt++.
  - At the edge where cnt==WIDTH-1 (the WIDTH-th iteration): data_o=final acc, zero_o=(final acc==0), state -> OUT.
  - out_valid_o is first high WIDTH+1 cycles after the accept cycle.
  - No early termination; latency is fixed.
  - Result is the low WIDTH bits of the product, identical for signed and unsigned operands.
- Arithmetic:
  - add/addi: data1+data2 mod 2^WIDTH.
  - sub: data1-data2 mod 2^WIDTH.
  - and/xor: bitwise.
  - sll: data1 << data2[SHAMT_W-1:0].
  - srai: arithmetic (sign-filling) right shift of data1 by data2[SHAMT_W-1:0].
  - Upper bits of data2 are ignored for shifts.
- OUT:
  - out_valid_o=1; data_o and zero_o held stable while out_ready_i=0.
  - When out_ready_i=1: state -> IDLE at that edge, out_valid_o=0 next cycle, in_ready_o=1 next cycle.
  - No same-cycle pass-through; peak throughput is one single-cycle op per 2 cycles.
- data_o and zero_o retain their last value after handoff until the next result is loaded.
- in_valid_i while not ready: ignored; the requester must hold it.

Test Plan:
- add 5+7 (ALUCtrl_i=011) -> data_o=12, zero_o=0, out_valid_o high exactly 1 cycle after accept; addi 0xFFFFFFFF+1 (110) -> data_o=0, zero_o=1.
- sub 7-7 -> 0, zero_o=1; sub 0-1 -> 0xFFFFFFFF; and 0xF0F0F0F0 & 0x0FF00FF0 -> 0x00F000F0; xor 0xAAAAAAAA ^ 0xFFFFFFFF -> 0x55555555.
- srai 0x80000000 by 4 -> 0xF8000000; sll 1 by 31 -> 0x80000000; sll 1 with data2=33 -> 0x00000002 (uses low 5 bits).
- mul 0xFFFFFFFF*3 -> 0xFFFFFFFD and 12345*6789 -> 83810205, out_valid_o first high 33 cycles after accept; in_ready_o=0, busy_o=1 throughout; data1_i/data2_i toggled mid-op have no effect.
- Backpressure: add result with out_ready_i=0 for 5 cycles -> data_o/zero_o/out_valid_o stable, in_ready_o=0; raise out_ready_i -> in_ready_o=1 next cycle, back-to-back op accepted.
- rst_i pulsed during 10th mul iteration -> out_valid_o never asserts, all outputs 0; subsequent xor 3^1 -> data_o=2 with normal latency.
